// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/sequencing controller.
package fetch_pkg;

   localparam int PC_W      = 9;
   localparam int INSTR_W   = 32;
   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 26;
   localparam int OPC_W     = OPC_MSB - OPC_LSB + 1;
   localparam int RETIRED_W = 16;

   localparam logic [OPC_W-1:0] HALT_OP_DEFAULT = 6'b111111;
   localparam int unsigned      TIMEOUT_DEFAULT = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_RESOLVE,
      ST_HALT
   } fetch_state_e;

   function automatic logic [RETIRED_W-1:0] sat_inc(input logic [RETIRED_W-1:0] v);
      return (&v) ? v : v + RETIRED_W'(1);
   endfunction

endpackage

// File: rtl/fetch_timeout.sv
// Loadable down-counter bounding how long a fetch may wait for its acknowledge.
module fetch_timeout #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: non-blocking assignment so all registers update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Loaded with TIMEOUT-1 on entry, so zero is reached on the TIMEOUT-th waiting cycle.
   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_controller.sv
// Sequencer: fetches from instruction memory, issues, waits for branch resolution
// and computes the next PC; halts on HALT_OP or on a fetch timeout.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter logic [OPC_W-1:0] HALT_OP = HALT_OP_DEFAULT,
   parameter int unsigned      TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 imem_req,
   output logic [PC_W-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic [INSTR_W-1:0]   instr,
   output logic                 instr_valid,
   input  logic                 br_valid,
   input  logic                 br_taken,
   input  logic [PC_W-1:0]      br_target,
   input  logic                 ex_busy,
   output logic [PC_W-1:0]      pc,
   output logic                 halted,
   output logic                 fault,
   output logic [RETIRED_W-1:0] retired
);

   fetch_state_e           state_q, state_d;
   logic [PC_W-1:0]        pc_q, pc_d;
   logic [INSTR_W-1:0]     instr_q, instr_d;
   logic                   fault_q, fault_d;
   logic [RETIRED_W-1:0]   retired_q, retired_d;
   logic                   expire;
   logic                   is_halt_op;

   assign is_halt_op = (instr_q[OPC_MSB:OPC_LSB] == HALT_OP);

   fetch_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (state_d != ST_FETCH),
      .load_i   ((state_d == ST_FETCH) && (state_q != ST_FETCH)),
      .en_i     ((state_q == ST_FETCH) && !imem_ack),
      .expire_o (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An acknowledge in the last allowed cycle takes priority over the timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_HALT: if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack)    state_d = ST_ISSUE;
            else if (expire) state_d = ST_HALT;
         end
         ST_ISSUE:   state_d = is_halt_op ? ST_HALT : ST_RESOLVE;
         ST_RESOLVE: if (!ex_busy) state_d = ST_FETCH;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_req    = (state_q == ST_FETCH);
      instr_valid = (state_q == ST_ISSUE);
      halted      = (state_q == ST_HALT);
   end

   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               pc_d      = '0;
               fault_d   = 1'b0;
               retired_d = '0;
            end
         end
         ST_FETCH: begin
            if (imem_ack)    instr_d = imem_rdata;
            else if (expire) fault_d = 1'b1;
         end
         ST_ISSUE: begin
            if (!is_halt_op) retired_d = sat_inc(retired_q);
         end
         ST_RESOLVE: begin
            // Branch inputs only matter on the cycle the datapath releases the stall.
            if (!ex_busy) begin
               pc_d = (br_valid && br_taken) ? br_target : pc_q + PC_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         instr_q   <= '0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign instr     = instr_q;
   assign fault     = fault_q;
   assign retired   = retired_q;

endmodule
